// File: rtl/ahb_timer_pkg.sv
// Shared AHB-Lite encodings plus the timer register map and CTRL bit positions.
// Byte-lane helpers are common to all AHB-Lite slaves that use ahb_lite_slave_if.
package ahb_timer_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_PRESC  = 5'h04;
    localparam logic [4:0] OFF_LOAD   = 5'h08;
    localparam logic [4:0] OFF_VALUE  = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;
    localparam logic [4:0] OFF_NONE   = 5'h1C;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_ONESHOT = 2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Sizes wider than a word are not supported and strobe no lanes.
    function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] s;
        s = 4'b0000;
        case (size)
            HSIZE_BYTE: s = 4'b0001 << lane;
            HSIZE_HALF: s = lane[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: s = 4'b1111;
            default:    s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/ahb_lite_slave_if.sv
// Zero-wait-state AHB-Lite slave front end: captures the address phase and
// presents write enable, word offset and byte strobes during the data phase.
module ahb_lite_slave_if
    import ahb_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic [4:0] addr,
    input  logic [1:0] trans,
    input  logic       write,
    input  logic [2:0] size,
    input  logic       ready,
    output logic       wr_en,
    output logic [4:0] rd_offset,
    output logic [3:0] strb
);

    logic       accept;
    logic       dvld;
    logic       dwrite;
    logic [2:0] dsize;
    logic [1:0] dlane;
    logic       unused_trans;

    assign accept       = sel & ready & trans[1];
    assign unused_trans = trans[0];

    // Offset is held across unselected cycles; dvld alone qualifies the data phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvld      <= 1'b0;
            dwrite    <= 1'b0;
            dsize     <= HSIZE_WORD;
            dlane     <= 2'b00;
            rd_offset <= OFF_NONE;
        end else if (ready) begin
            dvld <= accept;
            if (accept) begin
                dwrite    <= write;
                dsize     <= size;
                dlane     <= addr[1:0];
                rd_offset <= {addr[4:2], 2'b00};
            end
        end
    end

    assign wr_en = dvld & dwrite;
    assign strb  = byte_strobe(dsize, dlane);

endmodule

// File: rtl/ahb_timer.sv
// AHB-Lite timer: prescaled 32-bit down-counter with periodic/one-shot reload
// and a sticky match flag gated onto IRQ.
module ahb_timer
    import ahb_timer_pkg::*;
#(
    parameter int PW = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        IRQ
);

    logic          wr_en;
    logic [4:0]    offset;
    logic [3:0]    strb;

    logic [2:0]    ctrl;
    logic [PW-1:0] presc;
    logic [PW-1:0] pcnt;
    logic [31:0]   load;
    logic [31:0]   value;
    logic          flag;

    logic [31:0]   ctrl_w;
    logic [31:0]   presc_w;
    logic [31:0]   load_w;
    logic          wr_ctrl, wr_presc, wr_load, wr_status;
    logic          tick, term, en_rise;
    logic          unused_bits;

    ahb_lite_slave_if u_if (
        .clk       (HCLK),
        .rst       (HRESET),
        .sel       (HSEL),
        .addr      (HADDR[4:0]),
        .trans     (HTRANS),
        .write     (HWRITE),
        .size      (HSIZE),
        .ready     (HREADY),
        .wr_en     (wr_en),
        .rd_offset (offset),
        .strb      (strb)
    );

    assign wr_ctrl   = wr_en && (offset == OFF_CTRL);
    assign wr_presc  = wr_en && (offset == OFF_PRESC);
    assign wr_load   = wr_en && (offset == OFF_LOAD);
    assign wr_status = wr_en && (offset == OFF_STATUS);

    assign ctrl_w  = merge_bytes({29'd0, ctrl}, HWDATA, strb);
    assign presc_w = merge_bytes(32'(presc), HWDATA, strb);
    assign load_w  = merge_bytes(load, HWDATA, strb);

    assign tick    = ctrl[CTRL_EN] && (pcnt == presc);
    assign term    = tick && (value == 32'd0);
    assign en_rise = wr_ctrl && ctrl_w[CTRL_EN] && !ctrl[CTRL_EN];

    assign unused_bits = ^{HADDR[31:5], ctrl_w[31:3], presc_w};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ctrl  <= '0;
            presc <= '0;
            pcnt  <= '0;
            load  <= '0;
            value <= '0;
            flag  <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl <= ctrl_w[2:0];
            else if (term && ctrl[CTRL_ONESHOT])
                ctrl[CTRL_EN] <= 1'b0;

            if (wr_presc)
                presc <= presc_w[PW-1:0];

            if (wr_load)
                load <= load_w;

            // A LOAD write overrides any decrement or reload from a coincident tick.
            if (wr_load)
                value <= load_w;
            else if (tick) begin
                if (value != 32'd0)
                    value <= value - 32'd1;
                else if (!ctrl[CTRL_ONESHOT])
                    value <= load;
            end

            if (wr_load || en_rise)
                pcnt <= '0;
            else if (ctrl[CTRL_EN])
                pcnt <= tick ? '0 : pcnt + PW'(1);

            // Hardware set beats a same-cycle W1C.
            if (term)
                flag <= 1'b1;
            else if (wr_status && strb[0] && HWDATA[0])
                flag <= 1'b0;
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        case (offset)
            OFF_CTRL:   HRDATA = {29'd0, ctrl};
            OFF_PRESC:  HRDATA = 32'(presc);
            OFF_LOAD:   HRDATA = load;
            OFF_VALUE:  HRDATA = value;
            OFF_STATUS: HRDATA = {31'd0, flag};
            default:    HRDATA = 32'd0;
        endcase
    end

    assign IRQ       = flag & ctrl[CTRL_IE];
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

endmodule
